// File: rtl/wb_queue.sv
// Writeback queue feeding the two write ports of the 8x16 register file, in program order.
// Optional macro WB_QUEUE_FWD_EN adds three combinational lookup ports into the queued results.
module wb_queue #(
   parameter int DEPTH = 4,
   parameter int DW    = 16,
   parameter int AW    = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in0_valid,
   input  logic [AW-1:0]                in0_dest,
   input  logic [DW-1:0]                in0_data,
   output logic                         in0_ready,
   input  logic                         in1_valid,
   input  logic [AW-1:0]                in1_dest,
   input  logic [DW-1:0]                in1_data,
   output logic                         in1_ready,
   input  logic                         hold,
   output logic                         write0,
   output logic [AW-1:0]                num_write0,
   output logic [DW-1:0]                data_write0,
   output logic                         write1,
   output logic [AW-1:0]                num_write1,
   output logic [DW-1:0]                data_write1,
`ifdef WB_QUEUE_FWD_EN
   input  logic [AW-1:0]                fwd_num0,
   input  logic [AW-1:0]                fwd_num1,
   input  logic [AW-1:0]                fwd_num2,
   output logic                         fwd_hit0,
   output logic                         fwd_hit1,
   output logic                         fwd_hit2,
   output logic [DW-1:0]                fwd_data0,
   output logic [DW-1:0]                fwd_data1,
   output logic [DW-1:0]                fwd_data2,
`endif
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [AW-1:0] dest_q [DEPTH];
   logic [AW-1:0] dest_d [DEPTH];
   logic [DW-1:0] data_q [DEPTH];
   logic [DW-1:0] data_d [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr1_s, wr_ptr1_s, wr_slot1_s;
   logic [CW-1:0] count_q, count_d;
   logic          acc0_s, acc1_s;
   logic          drain0_s, drain1_s;

   // Readiness looks only at registered occupancy; a same-cycle drain is not credited.
   always_comb begin
      in0_ready = (count_q <= CW'(DEPTH - 1));
      in1_ready = (count_q <= CW'(DEPTH - 2));
      acc0_s    = in0_valid && in0_ready;
      acc1_s    = in1_valid && in1_ready;
      drain0_s  = (count_q >= CW'(1)) && !hold;
      drain1_s  = (count_q >= CW'(2)) && !hold;
      rd_ptr1_s = rd_ptr_q + PW'(1);
      count     = count_q;
   end

   // Write-port drive: oldest entry to port 0, next oldest to port 1; zeroed when idle.
   always_comb begin
      write0      = drain0_s;
      num_write0  = {AW{1'b0}};
      data_write0 = {DW{1'b0}};
      write1      = drain1_s;
      num_write1  = {AW{1'b0}};
      data_write1 = {DW{1'b0}};
      if (drain0_s) begin
         num_write0  = dest_q[rd_ptr_q];
         data_write0 = data_q[rd_ptr_q];
      end else begin
         num_write0  = {AW{1'b0}};
         data_write0 = {DW{1'b0}};
      end
      if (drain1_s) begin
         num_write1  = dest_q[rd_ptr1_s];
         data_write1 = data_q[rd_ptr1_s];
      end else begin
         num_write1  = {AW{1'b0}};
         data_write1 = {DW{1'b0}};
      end
   end

   // Next state: in1 lands behind in0 when both are accepted, otherwise at the write pointer.
   always_comb begin
      dest_d     = dest_q;
      data_d     = data_q;
      wr_ptr1_s  = wr_ptr_q + PW'(1);
      wr_slot1_s = acc0_s ? wr_ptr1_s : wr_ptr_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (acc0_s && (PW'(i) == wr_ptr_q)) begin
            dest_d[i] = in0_dest;
            data_d[i] = in0_data;
         end else if (acc1_s && (PW'(i) == wr_slot1_s)) begin
            dest_d[i] = in1_dest;
            data_d[i] = in1_data;
         end else begin
            dest_d[i] = dest_q[i];
            data_d[i] = data_q[i];
         end
      end
      wr_ptr_d = wr_ptr_q + PW'(acc0_s) + PW'(acc1_s);
      rd_ptr_d = rd_ptr_q + PW'(drain0_s) + PW'(drain1_s);
      count_d  = count_q + CW'(acc0_s) + CW'(acc1_s) - CW'(drain0_s) - CW'(drain1_s);
   end

   // State registers; reset discards every queued result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q <= {PW{1'b0}};
         wr_ptr_q <= {PW{1'b0}};
         count_q  <= {CW{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            dest_q[i] <= {AW{1'b0}};
            data_q[i] <= {DW{1'b0}};
         end
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         for (int i = 0; i < DEPTH; i++) begin
            dest_q[i] <= dest_d[i];
            data_q[i] <= data_d[i];
         end
      end
   end

`ifdef WB_QUEUE_FWD_EN
   logic [AW-1:0] fwd_num_s  [3];
   logic          fwd_hit_s  [3];
   logic [DW-1:0] fwd_data_s [3];

   // Lookup walks entries oldest to youngest so the youngest match is the one kept.
   always_comb begin
      logic [PW-1:0] idx;
      logic          match;
      fwd_num_s[0] = fwd_num0;
      fwd_num_s[1] = fwd_num1;
      fwd_num_s[2] = fwd_num2;
      idx   = {PW{1'b0}};
      match = 1'b0;
      for (int k = 0; k < 3; k++) begin
         fwd_hit_s[k]  = 1'b0;
         fwd_data_s[k] = {DW{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            idx   = rd_ptr_q + PW'(i);
            match = (CW'(i) < count_q) && (dest_q[idx] == fwd_num_s[k]);
            fwd_hit_s[k]  = fwd_hit_s[k] | match;
            fwd_data_s[k] = match ? data_q[idx] : fwd_data_s[k];
         end
      end
      fwd_hit0  = fwd_hit_s[0];
      fwd_hit1  = fwd_hit_s[1];
      fwd_hit2  = fwd_hit_s[2];
      fwd_data0 = fwd_data_s[0];
      fwd_data1 = fwd_data_s[1];
      fwd_data2 = fwd_data_s[2];
   end
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: vector table for handshakes/occupancy, queue scoreboard for write-port data.
// Define WB_QUEUE_FWD_EN to also exercise the lookup ports.
module tb_wb_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        in0_valid, in1_valid, hold;
   logic [2:0]  in0_dest, in1_dest;
   logic [15:0] in0_data, in1_data;
   logic        in0_ready, in1_ready;
   logic        write0, write1;
   logic [2:0]  num_write0, num_write1;
   logic [15:0] data_write0, data_write1;
   logic [2:0]  count;
`ifdef WB_QUEUE_FWD_EN
   logic [2:0]  fwd_num0 = 3'd0, fwd_num1 = 3'd0, fwd_num2 = 3'd0;
   logic        fwd_hit0, fwd_hit1, fwd_hit2;
   logic [15:0] fwd_data0, fwd_data1, fwd_data2;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] rf [8];

   typedef struct packed {
      logic [2:0]  dest;
      logic [15:0] data;
   } ent_t;
   ent_t sb [$];

   typedef struct packed {
      logic        hold;
      logic        v0;
      logic [2:0]  d0;
      logic [15:0] x0;
      logic        v1;
      logic [2:0]  d1;
      logic [15:0] x1;
      logic [2:0]  cnt;
      logic        r0;
      logic        r1;
   } vec_t;

   localparam int NV = 30;
   vec_t vecs [NV];

   wb_queue #(.DEPTH(4), .DW(16), .AW(3)) dut (
      .clk(clk), .rst(rst),
      .in0_valid(in0_valid), .in0_dest(in0_dest), .in0_data(in0_data), .in0_ready(in0_ready),
      .in1_valid(in1_valid), .in1_dest(in1_dest), .in1_data(in1_data), .in1_ready(in1_ready),
      .hold(hold),
      .write0(write0), .num_write0(num_write0), .data_write0(data_write0),
      .write1(write1), .num_write1(num_write1), .data_write1(data_write1),
`ifdef WB_QUEUE_FWD_EN
      .fwd_num0(fwd_num0), .fwd_num1(fwd_num1), .fwd_num2(fwd_num2),
      .fwd_hit0(fwd_hit0), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
      .fwd_data0(fwd_data0), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
`endif
      .count(count)
   );

   always #5 clk = ~clk;

   // Register file stand-in: port 1 is applied last.
   always @(posedge clk) begin
      if (write0) rf[num_write0] <= data_write0;
      if (write1) rf[num_write1] <= data_write1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic h, input logic v0, input logic [2:0] d0,
                               input logic [15:0] x0, input logic v1, input logic [2:0] d1,
                               input logic [15:0] x1, input logic [2:0] cnt,
                               input logic r0, input logic r1);
      vec_t v;
      v.hold = h; v.v0 = v0; v.d0 = d0; v.x0 = x0;
      v.v1 = v1; v.d1 = d1; v.x1 = x1;
      v.cnt = cnt; v.r0 = r0; v.r1 = r1;
      return v;
   endfunction

   // Called at a falling edge; returns at the next falling edge.
   task automatic apply(input int idx, input vec_t v);
      int   n_drain;
      ent_t e0, e1;
      logic ew0, ew1;
      in0_valid = v.v0; in0_dest = v.d0; in0_data = v.x0;
      in1_valid = v.v1; in1_dest = v.d1; in1_data = v.x1;
      hold = v.hold;
      #1;
      n_drain = v.hold ? 0 : ((sb.size() >= 2) ? 2 : sb.size());
      ew0 = (n_drain >= 1);
      ew1 = (n_drain >= 2);
      e0  = ew0 ? sb[0] : '0;
      e1  = ew1 ? sb[1] : '0;
      check($sformatf("v%0d count", idx), 32'(count), 32'(v.cnt));
      check($sformatf("v%0d in0_ready", idx), 32'(in0_ready), 32'(v.r0));
      check($sformatf("v%0d in1_ready", idx), 32'(in1_ready), 32'(v.r1));
      check($sformatf("v%0d write0", idx), 32'(write0), 32'(ew0));
      check($sformatf("v%0d num_write0", idx), 32'(num_write0), 32'(e0.dest));
      check($sformatf("v%0d data_write0", idx), 32'(data_write0), 32'(e0.data));
      check($sformatf("v%0d write1", idx), 32'(write1), 32'(ew1));
      check($sformatf("v%0d num_write1", idx), 32'(num_write1), 32'(e1.dest));
      check($sformatf("v%0d data_write1", idx), 32'(data_write1), 32'(e1.data));
      @(posedge clk);
      for (int k = 0; k < n_drain; k++) void'(sb.pop_front());
      if (v.v0 && v.r0) sb.push_back({v.d0, v.x0});
      if (v.v1 && v.r1) sb.push_back({v.d1, v.x1});
      @(negedge clk);
   endtask

   initial begin
      //              hold  v0    d0    x0          v1    d1    x1          cnt   r0    r1
      vecs[0]  = mk(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd0, 1'b1, 1'b1);
      vecs[1]  = mk(1'b0, 1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'h0000, 3'd0, 1'b1, 1'b1);
      vecs[2]  = mk(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd1, 1'b1, 1'b1);
      vecs[3]  = mk(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd0, 1'b1, 1'b1);
      vecs[4]  = mk(1'b0, 1'b1, 3'd5, 16'hAAAA, 1'b1, 3'd5, 16'h5555, 3'd0, 1'b1, 1'b1);
      vecs[5]  = mk(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd2, 1'b1, 1'b1);
      vecs[6]  = mk(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd0, 1'b1, 1'b1);
      vecs[7]  = mk(1'b1, 1'b1, 3'd1, 16'h1001, 1'b1, 3'd2, 16'h1002, 3'd0, 1'b1, 1'b1);
      vecs[8]  = mk(1'b1, 1'b1, 3'd3, 16'h1003, 1'b1, 3'd4, 16'h1004, 3'd2, 1'b1, 1'b1);
      vecs[9]  = mk(1'b1, 1'b1, 3'd5, 16'h1005, 1'b1, 3'd6, 16'h1006, 3'd4, 1'b0, 1'b0);
      vecs[10] = mk(1'b1, 1'b1, 3'd7, 16'h1007, 1'b1, 3'd0, 16'h1008, 3'd4, 1'b0, 1'b0);
      vecs[11] = mk(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd4, 1'b0, 1'b0);
      vecs[12] = mk(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd2, 1'b1, 1'b1);
      vecs[13] = mk(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd0, 1'b1, 1'b1);
      vecs[14] = mk(1'b1, 1'b1, 3'd1, 16'h2001, 1'b0, 3'd0, 16'h0000, 3'd0, 1'b1, 1'b1);
      vecs[15] = mk(1'b1, 1'b1, 3'd2, 16'h2002, 1'b0, 3'd0, 16'h0000, 3'd1, 1'b1, 1'b1);
      vecs[16] = mk(1'b1, 1'b1, 3'd3, 16'h2003, 1'b0, 3'd0, 16'h0000, 3'd2, 1'b1, 1'b1);
      vecs[17] = mk(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 16'h2004, 3'd3, 1'b1, 1'b0);
      vecs[18] = mk(1'b1, 1'b1, 3'd4, 16'h2014, 1'b1, 3'd5, 16'h2005, 3'd3, 1'b1, 1'b0);
      vecs[19] = mk(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd4, 1'b0, 1'b0);
      vecs[20] = mk(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd2, 1'b1, 1'b1);
      vecs[21] = mk(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd0, 1'b1, 1'b1);
      vecs[22] = mk(1'b0, 1'b1, 3'd1, 16'h3001, 1'b0, 3'd0, 16'h0000, 3'd0, 1'b1, 1'b1);
      vecs[23] = mk(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 16'h3002, 3'd1, 1'b1, 1'b1);
      vecs[24] = mk(1'b0, 1'b1, 3'd3, 16'h3003, 1'b0, 3'd0, 16'h0000, 3'd2, 1'b1, 1'b1);
      vecs[25] = mk(1'b1, 1'b1, 3'd4, 16'h3004, 1'b0, 3'd0, 16'h0000, 3'd1, 1'b1, 1'b1);
      vecs[26] = mk(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 16'h3005, 3'd2, 1'b1, 1'b1);
      vecs[27] = mk(1'b0, 1'b1, 3'd6, 16'h3006, 1'b0, 3'd0, 16'h0000, 3'd3, 1'b1, 1'b0);
      vecs[28] = mk(1'b1, 1'b1, 3'd7, 16'h3007, 1'b0, 3'd0, 16'h0000, 3'd2, 1'b1, 1'b1);
      vecs[29] = mk(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd3, 1'b1, 1'b0);

      rst = 1'b1;
      in0_valid = 1'b0; in0_dest = 3'd0; in0_data = 16'h0000;
      in1_valid = 1'b0; in1_dest = 3'd0; in1_data = 16'h0000;
      hold = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 7; i++) apply(i, vecs[i]);
      check("rf[3] after single", 32'(rf[3]), 32'h1234);
      check("rf[5] younger wins", 32'(rf[5]), 32'h5555);
      for (int i = 7; i < NV; i++) apply(i, vecs[i]);

      // Reset with three results still queued.
      hold = 1'b0;
      rst  = 1'b1;
      #1;
      check("rst count", 32'(count), 32'd0);
      check("rst write0", 32'(write0), 32'd0);
      check("rst write1", 32'(write1), 32'd0);
      check("rst in1_ready", 32'(in1_ready), 32'd1);
      @(negedge clk);
      #1;
      check("rst held write0", 32'(write0), 32'd0);
      rst = 1'b0;
      sb.delete();
      @(negedge clk);
      apply(100, mk(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd0, 1'b1, 1'b1));
      apply(101, mk(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd0, 1'b1, 1'b1));

`ifdef WB_QUEUE_FWD_EN
      apply(200, mk(1'b1, 1'b1, 3'd2, 16'h0001, 1'b0, 3'd0, 16'h0000, 3'd0, 1'b1, 1'b1));
      apply(201, mk(1'b1, 1'b1, 3'd2, 16'h0002, 1'b0, 3'd0, 16'h0000, 3'd1, 1'b1, 1'b1));
      in0_valid = 1'b0;
      fwd_num0 = 3'd2;
      fwd_num1 = 3'd6;
      #1;
      check("fwd0 hit", 32'(fwd_hit0), 32'd1);
      check("fwd0 data youngest", 32'(fwd_data0), 32'h0002);
      check("fwd1 miss hit", 32'(fwd_hit1), 32'd0);
      check("fwd1 miss data", 32'(fwd_data1), 32'h0000);
      hold = 1'b0;
      fwd_num2 = 3'd2;
      #1;
      check("fwd2 hit while draining", 32'(fwd_hit2), 32'd1);
      check("fwd2 data while draining", 32'(fwd_data2), 32'h0002);
      apply(202, mk(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd2, 1'b1, 1'b1));
      #1;
      check("fwd0 hit after drain", 32'(fwd_hit0), 32'd0);
      check("fwd0 data after drain", 32'(fwd_data0), 32'h0000);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
